bus_initiator_tx: RTL and testbench

Initiator-side serialiser for the serial bus that the slave-side address decoder listens to. It accepts one parallel request (address, write data, direction) through a valid/ready handshake. It drives a 16-bit address phase and, for writes, an 8-bit data phase onto the 1-bit bus, both LSB first. For reads, it collects the 8-bit serial read reply from the selected target, with a timeout. It sits between the bus master's control logic and the shared serial bus and arbiter mux.

---
 rtl/bus_initiator_tx.sv | 161 ++++++++++++++++
 tb/tb_bus_initiator_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_initiator_tx.sv
// Initiator-side serialiser: shifts a 16-bit address and an optional 8-bit write byte onto
// the 1-bit bus LSB first, or collects an 8-bit serial read reply with a silence timeout.
module bus_initiator_tx #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned RD_TIMEOUT = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic                  req_rw,
   output logic                  bus_data_out,
   output logic                  bus_data_out_valid,
   output logic                  bus_mode,
   output logic                  bus_rw,
   input  logic                  bus_rdata_in,
   input  logic                  bus_rdata_in_valid,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  timeout_err
);

   localparam int unsigned AIDX = $clog2(ADDR_WIDTH);
   localparam int unsigned DIDX = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {IDLE, ADDR, WDATA, RWAIT, RDATA, GAP} state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_nx;
   logic                  rw_q, rw_nx;
   logic [4:0]            cnt, cnt_nx;
   logic [DIDX-1:0]       rcnt, rcnt_nx;
   logic [7:0]            tcnt, tcnt_nx;
   logic [DATA_WIDTH-1:0] shift_q, shift_nx;
   logic [DATA_WIDTH-1:0] rdata_nx;
   logic                  terr_nx;
   logic                  ready_nx, valid_nx, mode_nx, brw_nx, bit_nx, done_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         addr_q             <= '0;
         wdata_q            <= '0;
         rw_q               <= 1'b0;
         cnt                <= '0;
         rcnt               <= '0;
         tcnt               <= '0;
         shift_q            <= '0;
         rdata              <= '0;
         timeout_err        <= 1'b0;
         req_ready          <= 1'b1;
         bus_data_out       <= 1'b0;
         bus_data_out_valid <= 1'b0;
         bus_mode           <= 1'b0;
         bus_rw             <= 1'b0;
         done               <= 1'b0;
      end else begin
         state              <= state_nx;
         addr_q             <= addr_nx;
         wdata_q            <= wdata_nx;
         rw_q               <= rw_nx;
         cnt                <= cnt_nx;
         rcnt               <= rcnt_nx;
         tcnt               <= tcnt_nx;
         shift_q            <= shift_nx;
         rdata              <= rdata_nx;
         timeout_err        <= terr_nx;
         req_ready          <= ready_nx;
         bus_data_out       <= bit_nx;
         bus_data_out_valid <= valid_nx;
         bus_mode           <= mode_nx;
         bus_rw             <= brw_nx;
         done               <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      addr_nx  = addr_q;
      wdata_nx = wdata_q;
      rw_nx    = rw_q;
      cnt_nx   = cnt;
      rcnt_nx  = rcnt;
      tcnt_nx  = tcnt;
      shift_nx = shift_q;
      rdata_nx = rdata;
      terr_nx  = timeout_err;

      unique case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               addr_nx  = req_addr;
               wdata_nx = req_wdata;
               rw_nx    = req_rw;
               cnt_nx   = '0;
               state_nx = ADDR;
            end
         end
         ADDR: begin
            if (cnt == 5'(ADDR_WIDTH - 1)) begin
               cnt_nx   = '0;
               rcnt_nx  = '0;
               tcnt_nx  = '0;
               shift_nx = '0;
               state_nx = rw_q ? WDATA : RWAIT;
            end else begin
               cnt_nx = cnt + 5'd1;
            end
         end
         WDATA: begin
            if (cnt == 5'(DATA_WIDTH - 1)) begin
               cnt_nx   = '0;
               terr_nx  = 1'b0;
               state_nx = GAP;
            end else begin
               cnt_nx = cnt + 5'd1;
            end
         end
         RWAIT, RDATA: begin
            // An arriving bit takes priority over an expiring timeout in the same cycle
            if (bus_rdata_in_valid) begin
               shift_nx[rcnt] = bus_rdata_in;
               rcnt_nx        = rcnt + 1'b1;
               tcnt_nx        = '0;
               state_nx       = RDATA;
               if (rcnt == DIDX'(DATA_WIDTH - 1)) begin
                  rdata_nx = shift_nx;
                  terr_nx  = 1'b0;
                  state_nx = GAP;
               end
            end else if (tcnt >= 8'(RD_TIMEOUT - 1)) begin
               tcnt_nx  = 8'(RD_TIMEOUT);
               rdata_nx = '0;
               terr_nx  = 1'b1;
               state_nx = GAP;
            end else begin
               tcnt_nx = tcnt + 8'd1;
            end
         end
         GAP:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      // Outputs are registered, so they are derived from the state being entered
      ready_nx = (state_nx == IDLE);
      valid_nx = (state_nx == ADDR) || (state_nx == WDATA);
      mode_nx  = (state_nx == WDATA) || (state_nx == RWAIT) || (state_nx == RDATA);
      brw_nx   = valid_nx && rw_nx;
      done_nx  = (state_nx == GAP);
      bit_nx   = 1'b0;
      if (state_nx == ADDR)
         bit_nx = addr_nx[cnt_nx[AIDX-1:0]];
      else if (state_nx == WDATA)
         bit_nx = wdata_nx[cnt_nx[DIDX-1:0]];
   end

endmodule

// File: tb/tb_bus_initiator_tx.sv
// Self-checking bench for bus_initiator_tx: random writes/reads against a cycle-level
// reference built from the transaction latency and read-timeout rules.
module tb_bus_initiator_tx;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 8;
   localparam int unsigned RT = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          req_rw = 1'b0;
   logic          bus_data_out, bus_data_out_valid, bus_mode, bus_rw;
   logic          bus_rdata_in = 1'b0;
   logic          bus_rdata_in_valid = 1'b0;
   logic          done;
   logic [DW-1:0] rdata;
   logic          timeout_err;

   int            tests = 0;
   int            fails = 0;
   logic [DW-1:0] exp_rdata = '0;
   int            gaps[8];

   bus_initiator_tx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(RT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rw(req_rw),
      .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
      .bus_mode(bus_mode), .bus_rw(bus_rw),
      .bus_rdata_in(bus_rdata_in), .bus_rdata_in_valid(bus_rdata_in_valid),
      .done(done), .rdata(rdata), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // {req_ready, valid, mode, rw, data, done}
   function automatic logic [5:0] observed();
      return {req_ready, bus_data_out_valid, bus_mode, bus_rw, bus_data_out, done};
   endfunction

   // Expected tuple k cycles after a write handshake
   function automatic logic [5:0] exp_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int k);
      logic [AW-1:0] as;
      logic [DW-1:0] ds;
      if (k >= 1 && k <= 16) begin
         as = a >> (k - 1);
         return {4'b0101, as[0], 1'b0};
      end
      if (k >= 17 && k <= 24) begin
         ds = d >> (k - 17);
         return {4'b0111, ds[0], 1'b0};
      end
      if (k == 25) return 6'b000001;
      return 6'b100000;
   endfunction

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (observed() !== 6'b100000) begin
         fails++; $display("FAIL reset_outputs: got %b want 100000", observed());
      end
      tests++;
      if (rdata !== 8'h00 || timeout_err !== 1'b0) begin
         fails++; $display("FAIL reset_rdata: got rdata=%h terr=%b want 00/0", rdata, timeout_err);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit noise);
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b1) begin
         fails++; $display("FAIL write_ready_pre: got %b want 1", req_ready);
      end
      req_valid = 1'b1; req_rw = 1'b1; req_addr = a; req_wdata = d;
      bus_rdata_in_valid = noise ? 1'($urandom) : 1'b0;
      for (int k = 1; k <= 26; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         req_addr = 16'($urandom); req_wdata = 8'($urandom); req_rw = 1'($urandom);
         bus_rdata_in_valid = noise ? 1'($urandom) : 1'b0;
         bus_rdata_in = 1'($urandom);
         tests++;
         if (observed() !== exp_write(a, d, k)) begin
            fails++; $display("FAIL write_cycle a=%h d=%h k=%0d: got %b want %b", a, d, k, observed(), exp_write(a, d, k));
         end
         tests++;
         if (rdata !== exp_rdata) begin
            fails++; $display("FAIL write_rdata_held k=%0d: got %h want %h", k, rdata, exp_rdata);
         end
         if (k == 25) begin
            tests++;
            if (timeout_err !== 1'b0) begin
               fails++; $display("FAIL write_terr: got %b want 0", timeout_err);
            end
         end
      end
      bus_rdata_in_valid = 1'b0;
      req_rw = 1'b0;
   endtask

   // gaps[k] = silent cycles before reply bit k; nbits bits are sent, then silence
   task automatic test_read_case(input logic [AW-1:0] a, input logic [DW-1:0] b, input int nbits);
      logic          sv[$];
      logic          sd[$];
      logic [AW-1:0] as;
      logic [DW-1:0] acc, er;
      logic          et;
      int            dc, silent, got;
      for (int k = 0; k < nbits; k++) begin
         for (int g = 0; g < gaps[k]; g++) begin sv.push_back(1'b0); sd.push_back(1'($urandom)); end
         sv.push_back(1'b1); sd.push_back(b[k]);
      end
      for (int g = 0; g < int'(RT) + 2; g++) begin sv.push_back(1'b0); sd.push_back(1'($urandom)); end
      silent = 0; got = 0; acc = '0; er = '0; et = 1'b0; dc = -1;
      for (int c = 0; c < sv.size() && dc < 0; c++) begin
         if (sv[c]) begin
            acc[got] = sd[c]; got++; silent = 0;
            if (got == int'(DW)) begin dc = c + 1; er = acc; et = 1'b0; end
         end else begin
            silent++;
            if (silent == int'(RT)) begin dc = c + 1; er = '0; et = 1'b1; end
         end
      end

      @(negedge clk);
      tests++;
      if (req_ready !== 1'b1) begin
         fails++; $display("FAIL read_ready_pre: got %b want 1", req_ready);
      end
      req_valid = 1'b1; req_rw = 1'b0; req_addr = a; req_wdata = 8'($urandom);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         req_valid = 1'b0; req_addr = 16'($urandom); req_rw = 1'($urandom);
         as = a >> (k - 1);
         tests++;
         if (observed() !== {4'b0100, as[0], 1'b0}) begin
            fails++; $display("FAIL read_addr a=%h k=%0d: got %b want %b", a, k, observed(), {4'b0100, as[0], 1'b0});
         end
      end
      for (int c = 0; c <= dc; c++) begin
         @(negedge clk);
         bus_rdata_in_valid = (c < sv.size()) ? sv[c] : 1'b0;
         bus_rdata_in = (c < sv.size()) ? sd[c] : 1'b0;
         if (c < dc) begin
            tests++;
            if (observed() !== 6'b001000 || rdata !== exp_rdata) begin
               fails++; $display("FAIL read_wait a=%h c=%0d: got %b rdata=%h want 001000 rdata=%h", a, c, observed(), rdata, exp_rdata);
            end
         end else begin
            exp_rdata = er;
            tests++;
            if (observed() !== 6'b000001) begin
               fails++; $display("FAIL read_done a=%h c=%0d: got %b want 000001", a, c, observed());
            end
            tests++;
            if (rdata !== er || timeout_err !== et) begin
               fails++; $display("FAIL read_result a=%h: got rdata=%h terr=%b want %h/%b", a, rdata, timeout_err, er, et);
            end
         end
      end
      @(negedge clk);
      bus_rdata_in_valid = 1'b0;
      tests++;
      if (observed() !== 6'b100000) begin
         fails++; $display("FAIL read_idle_after: got %b want 100000", observed());
      end
   endtask

   task automatic test_read();
      gaps = '{2, 0, 0, 0, 1, 0, 0, 0};
      test_read_case(16'h8004, 8'h3C, 8);
      gaps = '{0, 0, 0, int'(RT) - 1, 0, 0, 0, 0};
      test_read_case(16'($urandom), 8'($urandom), 8);
      for (int n = 0; n < 5; n++) begin
         for (int k = 0; k < 8; k++)
            gaps[k] = ($urandom_range(0, 7) == 0) ? int'(RT) - 1 : int'($urandom_range(0, 3));
         test_read_case(16'($urandom), 8'($urandom), 8);
      end
   endtask

   task automatic test_timeout();
      gaps = '{0, 0, 0, 0, 0, 0, 0, 0};
      test_read_case(16'h0010, 8'h00, 0);
      gaps = '{1, 0, 2, 0, 0, 0, 0, 0};
      test_read_case(16'($urandom), 8'hFF, 5);
      gaps = '{0, 0, int'(RT), 0, 0, 0, 0, 0};
      test_read_case(16'($urandom), 8'($urandom), 8);
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] a1, a2;
      logic [DW-1:0] d1, d2;
      logic [5:0]    e;
      a1 = 16'($urandom); a2 = 16'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
      @(negedge clk);
      req_valid = 1'b1; req_rw = 1'b1; req_addr = a1; req_wdata = d1;
      for (int k = 1; k <= 52; k++) begin
         @(negedge clk);
         if (k == 1) begin req_addr = a2; req_wdata = d2; end
         if (k == 27) req_valid = 1'b0;
         e = (k <= 26) ? exp_write(a1, d1, k) : exp_write(a2, d2, k - 26);
         tests++;
         if (observed() !== e) begin
            fails++; $display("FAIL b2b_cycle k=%0d: got %b want %b", k, observed(), e);
         end
      end
      req_valid = 1'b0;
   endtask

   task automatic test_spurious_rdata();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus_rdata_in_valid = 1'b1; bus_rdata_in = 1'($urandom);
         tests++;
         if (observed() !== 6'b100000 || rdata !== exp_rdata) begin
            fails++; $display("FAIL idle_spurious i=%0d: got %b rdata=%h want 100000 rdata=%h", i, observed(), rdata, exp_rdata);
         end
      end
      bus_rdata_in_valid = 1'b0;
      test_write(16'($urandom), 8'($urandom), 1'b1);
   endtask

   task automatic test_reset_mid();
      logic [AW-1:0] a;
      a = 16'($urandom);
      @(negedge clk);
      req_valid = 1'b1; req_rw = 1'b1; req_addr = a; req_wdata = 8'($urandom);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
      tests++;
      if (observed() !== exp_write(a, req_wdata, 10)) begin
         fails++; $display("FAIL rstmid_bit9: got %b want %b", observed(), exp_write(a, req_wdata, 10));
      end
      rst_n = 1'b0;
      #1;
      exp_rdata = '0;
      tests++;
      if (observed() !== 6'b100000 || rdata !== 8'h00 || timeout_err !== 1'b0) begin
         fails++; $display("FAIL rstmid_async: got %b rdata=%h terr=%b want 100000/00/0", observed(), rdata, timeout_err);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 2) rst_n = 1'b1;
         tests++;
         if (observed() !== 6'b100000) begin
            fails++; $display("FAIL rstmid_hold i=%0d: got %b want 100000", i, observed());
         end
      end
      @(negedge clk);
      tests++;
      if (observed() !== 6'b100000) begin
         fails++; $display("FAIL rstmid_no_done: got %b want 100000", observed());
      end
      test_write(16'($urandom), 8'($urandom), 1'b0);
   endtask

   initial begin
      test_reset();
      test_write(16'h4123, 8'hA5, 1'b0);
      for (int n = 0; n < 3; n++) test_write(16'($urandom), 8'($urandom), 1'b0);
      test_read();
      test_timeout();
      test_back_to_back();
      test_spurious_rdata();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
